// File: rtl/sfi_store_guard.sv
// Pipelined SFI store guard: one register stage that rewrites, flags or squashes
// store beats whose address tag falls outside the sandbox segment.
module sfi_store_guard #(
   parameter int unsigned     ADDR_W    = 32,
   parameter int unsigned     TAG_W     = 8,
   parameter logic [TAG_W-1:0] RESET_TAG = TAG_W'(8'hA2),
   parameter bit              EN_DWORD  = 1'b1,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [TAG_W-1:0]  cfg_tag,
   input  logic [1:0]        mode,
   input  logic              trap_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_instr,
   output logic              out_viol,
   output logic [CNT_W-1:0]  viol_cnt,
   output logic              trap
);

   localparam int unsigned LOW_W = ADDR_W - TAG_W;
   localparam int unsigned OP_W  = 6;

   localparam logic [1:0] MODE_MONITOR = 2'b01;
   localparam logic [1:0] MODE_BLOCK   = 2'b10;

   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              out_viol_q, out_viol_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              trap_q, trap_d;

   logic [OP_W-1:0]   opcode_c;
   logic              is_store_c;
   logic              viol_c;
   logic              accept_c;

   assign opcode_c = in_instr[31:26];

   // Store opcode decode; doubleword stores only when enabled
   always_comb begin
      is_store_c = 1'b0;
      unique case (opcode_c)
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E, 6'h38: is_store_c = 1'b1;
         6'h2C, 6'h2D, 6'h3C, 6'h3F:               is_store_c = EN_DWORD;
         default:                                  is_store_c = 1'b0;
      endcase
   end

   assign viol_c   = is_store_c && (in_addr[ADDR_W-1 -: TAG_W] != tag_q);
   assign in_ready = !out_valid_q || out_ready;
   assign accept_c = in_valid && in_ready;

   // Next-state: payload stage, tag register, counter and trap
   always_comb begin
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_instr_d = out_instr_q;
      out_viol_d  = out_viol_q;
      tag_d       = tag_q;
      cnt_d       = cnt_q;
      trap_d      = trap_q;

      if (accept_c) begin
         out_valid_d = 1'b1;
         out_addr_d  = in_addr;
         out_instr_d = in_instr;
         out_viol_d  = viol_c;
         if (viol_c) begin
            unique case (mode)
               MODE_MONITOR: ;
               MODE_BLOCK:   out_instr_d = 32'h0;
               default:      out_addr_d  = {tag_q, in_addr[LOW_W-1:0]};
            endcase
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (cfg_we) begin
         tag_d = cfg_tag;
      end

      // Clear first so a same-cycle violation lands on a zeroed count
      if (trap_clr) begin
         cnt_d  = '0;
         trap_d = 1'b0;
      end
      if (accept_c && viol_c) begin
         trap_d = 1'b1;
         if (cnt_d != {CNT_W{1'b1}}) begin
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q       <= RESET_TAG;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_instr_q <= '0;
         out_viol_q  <= 1'b0;
         cnt_q       <= '0;
         trap_q      <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_instr_q <= out_instr_d;
         out_viol_q  <= out_viol_d;
         cnt_q       <= cnt_d;
         trap_q      <= trap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_instr = out_instr_q;
   assign out_viol  = out_viol_q;
   assign viol_cnt  = cnt_q;
   assign trap      = trap_q;

endmodule

// File: doc/sfi_store_guard.md
Name: sfi_store_guard

Overview:
- Pipelined, parametrised successor to the combinational SFI store rewriter.
- Sits between decode/address-generation and the memory stage of the MIPS core. Accepts one {effective address, instruction} pair per beat over a valid/ready handshake.
- For store instructions whose address top TAG_W bits differ from the sandbox segment tag, it does one of three things, per a runtime mode: rewrites the tag, passes the beat unchanged and flags it, or squashes it to a NOP.
- Keeps a saturating violation counter and a sticky trap flag for the monitor.

Parameters:
- ADDR_W, 32, effective-address width in bits.
- TAG_W, 8, number of address MSBs forming the segment tag.
- RESET_TAG, 8'hA2, sandbox tag loaded at reset (TAG_W bits).
- EN_DWORD, 1, when 1 treat SD/SDL/SDR/SCD as stores; when 0 they pass untouched.
- CNT_W, 16, width of the violation counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  load cfg_tag into the tag register.
- cfg_tag  in  TAG_W  new sandbox tag.
- mode  in  2  00 rewrite, 01 monitor, 10 block, 11 same as 00.
- trap_clr  in  1  clear sticky trap and counter.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_addr  in  ADDR_W  effective address.
- in_instr  in  32  instruction word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_addr  out  ADDR_W  sanitised address.
- out_instr  out  32  instruction or NOP.
- out_viol  out  1  beat was an out-of-sandbox store.
- viol_cnt  out  CNT_W  saturating violation count.
- trap  out  1  sticky; set on first violation.

Behaviour:
- Reset values (async, rst_n low):
  - out_valid=0, out_addr=0, out_instr=0, out_viol=0.
  - viol_cnt=0, trap=0, tag register=RESET_TAG.
  - in_ready=1 immediately after reset.
- Store decode uses opcode = in_instr[31:26]:
  - Always stores: SB 28, SH 29, SWL 2A, SW 2B, SWR 2E, SC 38.
  - Stores only when EN_DWORD=1: SDL 2C, SDR 2D, SCD 3C, SD 3F.
  - All other opcodes are non-stores and are never modified or flagged.
- viol = store AND in_addr[ADDR_W-1 -: TAG_W] != tag register.
- Single register stage, latency 1 cycle:
  - in_ready = !out_valid || out_ready.
  - Transfer occurs when in_valid && in_ready; the register loads on the next edge.
  - Output holds stable while out_valid && !out_ready.
  - Full throughput: 1 beat/cycle with out_ready held high.
- Per-mode result when viol=1:
  - Rewrite: out_addr = {tag, in_addr[ADDR_W-TAG_W-1:0]}, out_instr = in_instr.
  - Monitor: out_addr = in_addr, out_instr = in_instr.
  - Block: out_addr = in_addr, out_instr = 32'h0 (NOP).
  - out_viol=1 in all modes.
- When viol=0, out_addr, out_instr pass unchanged and out_viol=0.
- Mode and tag are sampled at the accept cycle. A cfg_we in the same cycle as an accept does not affect that beat; the new tag applies from the next cycle.
- Counter and trap:
  - On each accepted beat with viol=1, viol_cnt increments, saturating at all-ones, and trap is set.
  - trap_clr zeroes both on the next edge.
  - If trap_clr and a violating accept occur in the same cycle, clear wins for the count, then the new violation is applied: viol_cnt=1, trap=1.
- Reset asserted mid-stream drops any held beat (out_valid=0). No partial counts survive reset.
- Stalled beats are counted once, at acceptance, not per stall cycle.

Test Plan:
- Reset, tag A2, mode 00; send addr FAFA0000, instr A0111111 (SB) → next cycle out_addr A2FA0000, out_instr A0111111, out_viol=1, viol_cnt=1, trap=1.
- Mode 00; send in-sandbox SWR addr A2FACE09, instr B8111111, then non-store addr 00213020, instr 00432820 → both outputs unchanged, out_viol=0, viol_cnt unchanged.
- Send addr 2A321403, instr FC111111 (SD) with EN_DWORD=1 → out_addr A2321403, out_viol=1. Same stimulus with EN_DWORD=0 → passes unchanged, out_viol=0.
- Mode 01 then 10 with addr FFCAD007, instr AC111111 (SW):
  - Mode 01 → out_addr FFCAD007, out_instr AC111111.
  - Mode 10 → out_addr FFCAD007, out_instr 00000000.
  - Both set out_viol=1.
- Back-to-back violating stores with out_ready low for 3 cycles → in_ready=0 while full, output held stable, each beat counted exactly once. With CNT_W=2 and 5 violations, viol_cnt stops at 3; trap_clr → 0.
- cfg_we with cfg_tag=B0 in the accept cycle of store addr 01000002 → that beat gives A2000002; the next identical beat gives B0000002. Assert rst_n low while out_valid=1 → out_valid=0, counter=0, tag returns to A2.
